// File: rtl/ray_frame_sequencer.sv
// Ray-tracer config-bus master: one-time register setup, then per frame camera Q/start writes and status polling; one request in flight, held until ms_taken_i.
// DOUBLE_BUFFER_EN: alternate frame buffers A/B per frame and publish the finished buffer on display_address_o.
module ray_frame_sequencer #(
    parameter int POSITION_WIDTH = 16,
    parameter int DATA_WIDTH     = 24,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int BASE_WIDTH     = 5,
    parameter int ID_WIDTH       = 4,
    parameter logic [ADDRESS_WIDTH-BASE_WIDTH-1:0] CONFIG_BASE = '0,
    parameter logic [ID_WIDTH-1:0] BUS_ID = '0,
    parameter int POLL_GAP       = 64
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               go_i,
    input  logic                               abort_i,
    input  logic [15:0]                        frame_count_i,
    input  logic [2:0][POSITION_WIDTH-1:0]     camera_q0_i,
    input  logic [2:0][POSITION_WIDTH-1:0]     delta_q_i,
    input  logic [2:0][POSITION_WIDTH-1:0]     camera_v_i,
    input  logic [2:0][POSITION_WIDTH-1:0]     camera_x_i,
    input  logic [2:0][POSITION_WIDTH-1:0]     camera_y_i,
    input  logic [11:0]                        width_i,
    input  logic [11:0]                        height_i,
    input  logic [ADDRESS_WIDTH-1:0]           material_address_i,
    input  logic [ADDRESS_WIDTH-1:0]           tree_address_i,
    input  logic [ADDRESS_WIDTH-1:0]           frame_address_a_i,
`ifdef DOUBLE_BUFFER_EN
    input  logic [ADDRESS_WIDTH-1:0]           frame_address_b_i,
    output logic [ADDRESS_WIDTH-1:0]           display_address_o,
`endif
    output logic                               ms_valid_o,
    input  logic                               ms_taken_i,
    output logic [ADDRESS_WIDTH-1:0]           ms_address_o,
    output logic [DATA_WIDTH-1:0]              ms_data_o,
    output logic                               ms_write_o,
    output logic [ID_WIDTH-1:0]                ms_id_o,
    input  logic                               sm_valid_i,
    output logic                               sm_taken_o,
    input  logic [DATA_WIDTH-1:0]              sm_data_i,
    input  logic [ID_WIDTH-1:0]                sm_id_i,
    output logic                               busy_o,
    output logic                               frame_done_o,
    output logic [15:0]                        frame_index_o
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_SETUP     = 4'd1;
    localparam logic [3:0] S_FRAME     = 4'd2;
    localparam logic [3:0] S_START     = 4'd3;
    localparam logic [3:0] S_GAP       = 4'd4;
    localparam logic [3:0] S_POLL_REQ  = 4'd5;
    localparam logic [3:0] S_POLL_WAIT = 4'd6;
    localparam logic [3:0] S_NEXT      = 4'd7;
    localparam logic [3:0] S_DONE      = 4'd8;

    localparam int GAP_W = $clog2(POLL_GAP + 1);

    logic [3:0]                         state_q, state_d;
    logic [3:0]                         step_q, step_d;
    logic                               ms_valid_q, ms_valid_d;
    logic                               abort_q, abort_d;
    logic [GAP_W-1:0]                   gap_q, gap_d;
    logic [15:0]                        frame_index_q, frame_index_d;
    logic [15:0]                        frame_count_q, frame_count_d;
    logic [2:0][POSITION_WIDTH-1:0]     q_q, q_d;
    logic [2:0][POSITION_WIDTH-1:0]     dq_q, dq_d;
    logic [ADDRESS_WIDTH-1:0]           display_q, display_d;

    logic [BASE_WIDTH-1:0]              offset;
    logic                               ms_write;
    logic [DATA_WIDTH-1:0]              wr_data;
    logic [ADDRESS_WIDTH-1:0]           frame_addr;
    logic                               last_step;
    logic [3:0]                         after_state;
    logic                               abort_now;
    logic                               resp_ok;
    logic                               poll_idle;
    logic                               unused_bits;

`ifdef DOUBLE_BUFFER_EN
    assign frame_addr        = frame_index_q[0] ? frame_address_b_i : frame_address_a_i;
    assign display_address_o = display_q;
`else
    assign frame_addr        = frame_address_a_i;
`endif

    assign unused_bits = ^{material_address_i[7:0], tree_address_i[7:0], frame_addr[7:0],
                           sm_data_i[DATA_WIDTH-1:3], sm_data_i[0], display_q};

    // Register offset is a pure function of state and step, so it stays stable while a request waits.
    always_comb begin
        offset   = '0;
        ms_write = 1'b1;
        case (state_q)
            S_SETUP: begin
                if (step_q == 4'd0)      offset = BASE_WIDTH'(1);
                else if (step_q == 4'd1) offset = BASE_WIDTH'(2);
                else                     offset = BASE_WIDTH'(step_q) + BASE_WIDTH'(5);
            end
            S_FRAME:    offset = (step_q == 4'd0) ? BASE_WIDTH'(3) : BASE_WIDTH'(step_q) + BASE_WIDTH'(3);
            S_POLL_REQ: ms_write = 1'b0;
            default: ;
        endcase
    end

    always_comb begin
        wr_data = '0;
        case (32'(offset))
            0:    wr_data = DATA_WIDTH'(ms_write);
            1:    wr_data = DATA_WIDTH'(material_address_i[ADDRESS_WIDTH-1:8]);
            2:    wr_data = DATA_WIDTH'(tree_address_i[ADDRESS_WIDTH-1:8]);
            3:    wr_data = DATA_WIDTH'(frame_addr[ADDRESS_WIDTH-1:8]);
            4:    wr_data = DATA_WIDTH'(q_q[0]);
            5:    wr_data = DATA_WIDTH'(q_q[1]);
            6:    wr_data = DATA_WIDTH'(q_q[2]);
            7:    wr_data = DATA_WIDTH'(camera_v_i[0]);
            8:    wr_data = DATA_WIDTH'(camera_v_i[1]);
            9:    wr_data = DATA_WIDTH'(camera_v_i[2]);
            'hA:  wr_data = DATA_WIDTH'(camera_x_i[0]);
            'hB:  wr_data = DATA_WIDTH'(camera_x_i[1]);
            'hC:  wr_data = DATA_WIDTH'(camera_x_i[2]);
            'hD:  wr_data = DATA_WIDTH'(camera_y_i[0]);
            'hE:  wr_data = DATA_WIDTH'(camera_y_i[1]);
            'hF:  wr_data = DATA_WIDTH'(camera_y_i[2]);
            'h10: wr_data = DATA_WIDTH'(width_i);
            'h11: wr_data = DATA_WIDTH'(height_i);
            default: ;
        endcase
    end

    always_comb begin
        last_step   = 1'b1;
        after_state = S_GAP;
        case (state_q)
            S_SETUP:    begin last_step = (step_q == 4'd12); after_state = S_FRAME; end
            S_FRAME:    begin last_step = (step_q == 4'd3);  after_state = S_START; end
            S_START:    after_state = S_GAP;
            S_POLL_REQ: after_state = S_POLL_WAIT;
            default: ;
        endcase
    end

    assign abort_now = abort_q | abort_i;
    assign sm_taken_o = (state_q == S_POLL_WAIT) && (sm_id_i == BUS_ID);
    assign resp_ok    = sm_taken_o && sm_valid_i;
    assign poll_idle  = !sm_data_i[2] && sm_data_i[1];

    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        ms_valid_d    = ms_valid_q;
        abort_d       = abort_q | (abort_i && state_q != S_IDLE);
        gap_d         = '0;
        frame_index_d = frame_index_q;
        frame_count_d = frame_count_q;
        q_d           = q_q;
        dq_d          = dq_q;
        display_d     = display_q;
        case (state_q)
            S_IDLE: begin
                if (go_i) begin
                    q_d           = camera_q0_i;
                    dq_d          = delta_q_i;
                    frame_count_d = frame_count_i;
                    frame_index_d = '0;
                    step_d        = '0;
                    state_d       = (frame_count_i == 16'd0) ? S_DONE : S_SETUP;
                end
            end
            S_SETUP, S_FRAME, S_START, S_POLL_REQ: begin
                if (ms_valid_q) begin
                    if (ms_taken_i) begin
                        ms_valid_d = 1'b0;
                        if (abort_now) begin
                            state_d = S_IDLE;
                        end else if (last_step) begin
                            step_d  = '0;
                            state_d = after_state;
                        end else begin
                            step_d = step_q + 4'd1;
                        end
                    end
                end else if (abort_now) begin
                    state_d = S_IDLE;
                end else begin
                    ms_valid_d = 1'b1;
                end
            end
            S_GAP: begin
                if (abort_now)                          state_d = S_IDLE;
                else if (gap_q == GAP_W'(POLL_GAP - 1)) state_d = S_POLL_REQ;
                else                                    gap_d = gap_q + GAP_W'(1);
            end
            S_POLL_WAIT: begin
                if (resp_ok) begin
                    if (abort_now)      state_d = S_IDLE;
                    else if (poll_idle) state_d = S_NEXT;
                    else                state_d = S_GAP;
                end
            end
            S_NEXT: begin
                frame_index_d = frame_index_q + 16'd1;
                display_d     = frame_addr;
                for (int i = 0; i < 3; i++) q_d[i] = q_q[i] + dq_q[i];
                state_d = (frame_index_q + 16'd1 == frame_count_q) ? S_DONE : S_FRAME;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // An abort never survives into the next sequence.
        if (state_q == S_IDLE || state_d == S_IDLE) abort_d = 1'b0;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            step_q        <= '0;
            ms_valid_q    <= 1'b0;
            abort_q       <= 1'b0;
            gap_q         <= '0;
            frame_index_q <= '0;
            frame_count_q <= '0;
            q_q           <= '0;
            dq_q          <= '0;
            display_q     <= frame_address_a_i;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            ms_valid_q    <= ms_valid_d;
            abort_q       <= abort_d;
            gap_q         <= gap_d;
            frame_index_q <= frame_index_d;
            frame_count_q <= frame_count_d;
            q_q           <= q_d;
            dq_q          <= dq_d;
            display_q     <= display_d;
        end
    end

    assign ms_valid_o    = ms_valid_q;
    assign ms_address_o  = {CONFIG_BASE, offset};
    assign ms_data_o     = wr_data;
    assign ms_write_o    = ms_write;
    assign ms_id_o       = BUS_ID;
    assign busy_o        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign frame_done_o  = (state_q == S_NEXT);
    assign frame_index_o = frame_index_q;

endmodule

// File: tb/tb_ray_frame_sequencer.sv
// Bench for ray_frame_sequencer: bus-slave model with stall/delay/foreign-ID knobs and a transaction scoreboard.
module tb_ray_frame_sequencer;

    localparam int          PG     = 8;
    localparam logic [3:0]  BUS_ID = 4'd0;
    localparam logic [31:0] MAT    = 32'h1234_5600;
    localparam logic [31:0] TREE   = 32'h00AB_CD00;
    localparam logic [31:0] FA     = 32'hDEAD_BE00;
    localparam logic [31:0] FB     = 32'h0F0F_0100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, go, abort;
    logic [15:0] frame_count;
    logic [2:0][15:0] cam_q0, delta_q, cam_v, cam_x, cam_y;
    logic [11:0] width, height;
    logic ms_valid, ms_taken, ms_write, sm_valid, sm_taken, busy, frame_done;
    logic [31:0] ms_addr;
    logic [23:0] ms_data, sm_data;
    logic [3:0]  ms_id, sm_id;
    logic [15:0] frame_index;
`ifdef DOUBLE_BUFFER_EN
    logic [31:0] display;
`endif

    ray_frame_sequencer #(.POLL_GAP(PG)) dut (
        .clock_i(clk), .reset_i(rst), .go_i(go), .abort_i(abort),
        .frame_count_i(frame_count), .camera_q0_i(cam_q0), .delta_q_i(delta_q),
        .camera_v_i(cam_v), .camera_x_i(cam_x), .camera_y_i(cam_y),
        .width_i(width), .height_i(height),
        .material_address_i(MAT), .tree_address_i(TREE), .frame_address_a_i(FA),
`ifdef DOUBLE_BUFFER_EN
        .frame_address_b_i(FB), .display_address_o(display),
`endif
        .ms_valid_o(ms_valid), .ms_taken_i(ms_taken), .ms_address_o(ms_addr),
        .ms_data_o(ms_data), .ms_write_o(ms_write), .ms_id_o(ms_id),
        .sm_valid_i(sm_valid), .sm_taken_o(sm_taken), .sm_data_i(sm_data), .sm_id_i(sm_id),
        .busy_o(busy), .frame_done_o(frame_done), .frame_index_o(frame_index)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [23:0] status_q[$];
    int stall_cfg = 0, rdelay_cfg = 0, foreign_cfg = 0;
    int rd_cnt = 0, resp_cnt = 0, done_cnt = 0, cyc = 0;
    logic go_with_abort = 1'b0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic wr, input logic [3:0] id, input logic [31:0] a, input logic [23:0] d);
        return {3'b000, wr, id, a, d};
    endfunction

    task automatic push_wr(input logic [4:0] off, input logic [23:0] d);
        exp_q.push_back(mk(1'b1, BUS_ID, {27'd0, off}, d));
    endtask

    // Bus slave: accepts requests after stall_cfg cycles, answers reads after rdelay_cfg cycles.
    initial begin
        logic p_valid, p_taken, p_write;
        logic [31:0] p_addr;
        logic [23:0] p_data;
        logic [3:0]  p_id;
        logic [63:0] e;
        int stall_cnt, rd_wait, foreign_left, last_rd, rd_in_frame;
        logic resp_acc;
        p_valid = 0; p_taken = 0; p_write = 0; p_addr = 0; p_data = 0; p_id = 0;
        stall_cnt = 0; rd_wait = -1; foreign_left = 0; last_rd = 0; rd_in_frame = 0; resp_acc = 0;
        ms_taken = 0; sm_valid = 0; sm_data = 0; sm_id = BUS_ID;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                ms_taken = 0; sm_valid = 0; p_valid = 0; p_taken = 0;
                stall_cnt = 0; rd_wait = -1; resp_acc = 0; rd_in_frame = 0;
                continue;
            end
            if (resp_acc) begin
                sm_valid = 0; resp_acc = 0; resp_cnt++;
            end
            if (p_valid && p_taken) begin
                chk_eq("txn_avail", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk_eq("txn", mk(p_write, p_id, p_addr, p_write ? p_data : 24'd0), e);
                end
                if (!p_write) begin
                    rd_cnt++;
                    if (rd_in_frame > 0) chk_eq("poll_gap", 64'((cyc - last_rd) >= PG), 64'd1);
                    rd_in_frame++;
                    last_rd = cyc;
                    rd_wait = rdelay_cfg;
                end else begin
                    rd_in_frame = 0;
                end
                stall_cnt = 0;
            end else if (p_valid) begin
                chk_eq("hold_vld", 64'(ms_valid), 64'd1);
                chk_eq("hold_fields", {3'b0, ms_write, ms_id, ms_addr, ms_data},
                                      {3'b0, p_write, p_id, p_addr, p_data});
            end
            if (rd_wait == 0) begin
                sm_valid = 1;
                sm_data = (status_q.size() != 0) ? status_q.pop_front() : 24'hFFFFFA;
                foreign_left = foreign_cfg;
                rd_wait = -1;
            end else if (rd_wait > 0) begin
                rd_wait--;
            end
            if (sm_valid) begin
                sm_id = (foreign_left > 0) ? BUS_ID + 4'd1 : BUS_ID;
                if (foreign_left > 0) foreign_left--;
            end
            if (ms_valid && stall_cnt < stall_cfg) begin
                ms_taken = 0; stall_cnt++;
            end else begin
                ms_taken = ms_valid;
            end
            p_valid = ms_valid; p_taken = ms_taken; p_write = ms_write;
            p_addr = ms_addr; p_data = ms_data; p_id = ms_id;
            #1;
            if (sm_valid && sm_id != BUS_ID) chk_eq("foreign_untaken", 64'(sm_taken), 64'd0);
            if (sm_valid && sm_taken) resp_acc = 1;
        end
    end

    // frameDone monitor; in double-buffer builds also checks the published buffer.
    initial begin
`ifdef DOUBLE_BUFFER_EN
        logic chk_disp;
        logic [31:0] exp_disp;
        chk_disp = 0; exp_disp = 0;
`endif
        forever begin
            @(negedge clk);
`ifdef DOUBLE_BUFFER_EN
            if (chk_disp) chk_eq("display_addr", 64'(display), 64'(exp_disp));
            chk_disp = frame_done;
            exp_disp = frame_index[0] ? FB : FA;
`endif
            if (frame_done && !rst) done_cnt++;
        end
    end

    task automatic run(input int cnt, input logic [2:0][15:0] q0, input logic [2:0][15:0] dq,
                       input int polls, input int stall, input int rdelay, input int foreign,
                       input bit abort_mode, input bit regap);
        logic [2:0][15:0] q;
        logic [31:0] fad;
        int d0, r0, n;
        stall_cfg = stall; rdelay_cfg = rdelay; foreign_cfg = foreign;
        q = q0;
        if (cnt > 0) begin
            push_wr(5'h01, MAT[31:8]);
            push_wr(5'h02, TREE[31:8]);
            for (int i = 0; i < 3; i++) push_wr(5'(7 + i),  {8'd0, cam_v[i]});
            for (int i = 0; i < 3; i++) push_wr(5'(10 + i), {8'd0, cam_x[i]});
            for (int i = 0; i < 3; i++) push_wr(5'(13 + i), {8'd0, cam_y[i]});
            push_wr(5'h10, {12'd0, width});
            push_wr(5'h11, {12'd0, height});
        end
        for (int f = 0; f < cnt; f++) begin
`ifdef DOUBLE_BUFFER_EN
            fad = (f % 2 == 1) ? FB : FA;
`else
            fad = FA;
`endif
            push_wr(5'h03, fad[31:8]);
            for (int i = 0; i < 3; i++) push_wr(5'(4 + i), {8'd0, q[i]});
            push_wr(5'h00, 24'd1);
            for (int p = 0; p < polls; p++) begin
                exp_q.push_back(mk(1'b0, BUS_ID, 32'd0, 24'd0));
                status_q.push_back((p == polls - 1) ? 24'hFFFFFA : ((p % 2 == 1) ? 24'h000004 : 24'h000006));
            end
            for (int i = 0; i < 3; i++) q[i] = q[i] + dq[i];
            if (abort_mode) break;
        end
        d0 = done_cnt; r0 = rd_cnt;
        @(negedge clk);
        frame_count = 16'(cnt); cam_q0 = q0; delta_q = dq; go = 1; abort = go_with_abort;
        @(negedge clk);
        go = 0; abort = 0;
        chk_eq("busy_on_go", 64'(busy), 64'(cnt != 0));
        if (regap) begin
            repeat (20) @(negedge clk);
            frame_count = 16'd0; go = 1;
            @(negedge clk);
            go = 0;
        end
        if (abort_mode) begin
            n = 0;
            while (rd_cnt == r0 && n < 2000) begin @(negedge clk); n++; end
            chk_eq("read_seen", 64'(rd_cnt != r0), 64'd1);
            abort = 1;
            @(negedge clk);
            abort = 0;
            r0 = resp_cnt; n = 0;
            while (resp_cnt == r0 && n < 100) begin @(negedge clk); n++; end
            chk_eq("abort_resp_taken", 64'(resp_cnt != r0), 64'd1);
            chk_eq("abort_idle", 64'(busy), 64'd0);
            repeat (PG + 5) @(negedge clk);
        end else begin
            n = 0;
            while (busy && n < 20000) begin @(negedge clk); n++; end
            chk_eq("idle_timeout", 64'(busy), 64'd0);
            repeat (3) @(negedge clk);
        end
        chk_eq("frames_done", 64'(done_cnt - d0), 64'(abort_mode ? 0 : cnt));
        chk_eq("frame_index", 64'(frame_index), 64'(abort_mode ? 0 : cnt));
        chk_eq("sb_empty", 64'(exp_q.size()), 64'd0);
        chk_eq("status_used", 64'(status_q.size()), 64'd0);
        chk_eq("busy_after", 64'(busy), 64'd0);
    endtask

    initial begin
        int n;
        rst = 1; go = 0; abort = 0; frame_count = 0;
        cam_q0 = '0; delta_q = '0;
        cam_v = {16'h0003, 16'h0002, 16'h0001};
        cam_x = {16'hA00C, 16'hB00B, 16'hC00A};
        cam_y = {16'h0F00, 16'h00F0, 16'h000F};
        width = 12'd640; height = 12'd480;
        repeat (3) @(negedge clk);
        chk_eq("rst_busy", 64'(busy), 64'd0);
        chk_eq("rst_done", 64'(frame_done), 64'd0);
        chk_eq("rst_index", 64'(frame_index), 64'd0);
        chk_eq("rst_ms_valid", 64'(ms_valid), 64'd0);
        chk_eq("rst_sm_taken", 64'(sm_taken), 64'd0);
`ifdef DOUBLE_BUFFER_EN
        chk_eq("rst_display", 64'(display), 64'(FA));
`endif
        rst = 0;
        @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        @(negedge clk);
        chk_eq("abort_idle_ignored", 64'(busy), 64'd0);

        go_with_abort = 1;
        run(1, {16'd30, 16'd20, 16'd10}, '0, 1, 0, 0, 0, 0, 0);
        go_with_abort = 0;
        run(3, {16'd30, 16'd20, 16'd10}, {16'h0100, 16'hFFFF, 16'h0001}, 1, 0, 2, 0, 0, 1);
        run(2, {16'h0006, 16'h0005, 16'hFFFF}, {16'h0000, 16'h0000, 16'h0002}, 1, 5, 0, 0, 0, 0);
        run(1, {16'd3, 16'd2, 16'd1}, '0, 4, 0, 1, 3, 0, 0);
        run(2, {16'd3, 16'd2, 16'd1}, {16'd1, 16'd1, 16'd1}, 1, 0, 5, 0, 1, 0);
        run(0, {16'd3, 16'd2, 16'd1}, '0, 1, 0, 0, 0, 0, 0);

        // Reset while a write is being stalled by the slave.
        stall_cfg = 1000;
        @(negedge clk);
        frame_count = 16'd1; go = 1;
        @(negedge clk);
        go = 0; n = 0;
        while (!ms_valid && n < 50) begin @(negedge clk); n++; end
        chk_eq("mid_valid_seen", 64'(ms_valid), 64'd1);
        rst = 1;
        @(negedge clk);
        chk_eq("mid_rst_valid", 64'(ms_valid), 64'd0);
        chk_eq("mid_rst_busy", 64'(busy), 64'd0);
        chk_eq("mid_rst_taken", 64'(sm_taken), 64'd0);
        @(negedge clk);
        rst = 0; stall_cfg = 0;
        exp_q.delete(); status_q.delete();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
